// File: rtl/soc_system_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : soc_system_pio_pkg
// Brief    : Shared register map and edge-mode constants for the PIO block.
// Revision : 1.0 - initial release
// ============================================================================
package soc_system_pio_pkg;

  // Avalon word addresses of the register file
  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_IN      = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
  localparam logic [2:0] ADDR_PULSE   = 3'd6;
  localparam logic [2:0] ADDR_STATUS  = 3'd7;

  // Edge capture modes
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Counter width able to hold the value n
  function automatic int count_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/soc_system_pio_out_gen2_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : soc_system_pio_sync_edge
// Brief    : Two-flop input synchroniser with primed edge detector. Emits a
//            one-cycle pulse per detected edge on each bit.
// Revision : 1.0 - initial release
// ============================================================================
module soc_system_pio_sync_edge
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int EDGE_TYPE = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_async,
  output logic [WIDTH-1:0] sync_value,
  output logic [WIDTH-1:0] edge_pulse
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev;
  logic [1:0]       fill;
  logic             primed;
  logic [WIDTH-1:0] raw_edge;

  // Synchroniser chain plus previous-sample register; fill/primed track when
  // prev first holds a genuine synchronised sample rather than a reset value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta   <= '0;
      sync   <= '0;
      prev   <= '0;
      fill   <= 2'b00;
      primed <= 1'b0;
    end else begin
      meta   <= in_async;
      sync   <= meta;
      prev   <= sync;
      fill   <= {fill[0], 1'b1};
      primed <= fill[1];
    end
  end

  generate
    if (EDGE_TYPE == EDGE_FALLING) begin : g_falling
      assign raw_edge = ~sync & prev;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign raw_edge = sync ^ prev;
    end else begin : g_rising
      assign raw_edge = sync & ~prev;
    end
  endgenerate

  assign sync_value = sync;
  // An input held steady through reset must not look like an edge
  assign edge_pulse = primed ? raw_edge : '0;

endmodule
`default_nettype wire

// File: rtl/soc_system_pio_out_gen2.sv
`default_nettype none
// ============================================================================
// Module   : soc_system_pio_out_gen2
// Brief    : Parametrised Avalon-MM PIO: output register with atomic set/clear
//            and self-timed pulse mode, synchronised input with edge capture
//            and masked level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module soc_system_pio_out_gen2
  import soc_system_pio_pkg::*;
#(
  parameter int          WIDTH        = 32,
  parameter logic [31:0] RESET_VALUE  = 32'd1023,
  parameter int          PULSE_CYCLES = 16,
  parameter int          EDGE_TYPE    = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam int               CNT_W      = count_width(PULSE_CYCLES);
  localparam logic [WIDTH-1:0] RESET_DATA = RESET_VALUE[WIDTH-1:0];
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] pulse_mask;
  logic [CNT_W-1:0] pulse_count;

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic             pulse_wr;
  logic             expire;
  logic             pulse_busy;
  logic [WIDTH-1:0] data_base;
  logic [WIDTH-1:0] data_next;
  logic [WIDTH-1:0] w1c_bits;
  logic [WIDTH-1:0] sync_value;
  logic [WIDTH-1:0] edge_pulse;

  assign wr_en      = chipselect & ~write_n;
  assign wd         = writedata[WIDTH-1:0];
  assign pulse_wr   = wr_en && (address == ADDR_PULSE);
  assign pulse_busy = (pulse_count != '0);
  // A PULSE write on the expiry cycle restarts the timer instead of clearing
  assign expire     = (pulse_count == CNT_ONE) && !pulse_wr;

  generate
    if (WIDTH < 32) begin : g_wd_upper
      logic unused_upper;
      assign unused_upper = ^writedata[31:WIDTH];
    end
  endgenerate

  soc_system_pio_sync_edge #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_sync_edge (
    .clk        (clk),
    .reset      (reset),
    .in_async   (in_port),
    .sync_value (sync_value),
    .edge_pulse (edge_pulse)
  );

  // Next output value: expiry clear first, then any CPU write on top of it
  always_comb begin
    data_base = expire ? (data_out & ~pulse_mask) : data_out;
    data_next = data_base;
    if (wr_en) begin
      case (address)
        ADDR_DATA:   data_next = wd;
        ADDR_OUTSET: data_next = data_base | wd;
        ADDR_OUTCLR: data_next = data_base & ~wd;
        ADDR_PULSE:  data_next = data_base | wd;
        default:     data_next = data_base;
      endcase
    end
  end

  // Output register, pulse mask and pulse countdown timer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out    <= RESET_DATA;
      pulse_mask  <= '0;
      pulse_count <= '0;
    end else begin
      data_out <= data_next;
      if (pulse_wr) begin
        pulse_mask  <= pulse_mask | wd;
        pulse_count <= PULSE_LOAD;
      end else begin
        if (expire) begin
          pulse_mask <= '0;
        end
        if (pulse_busy) begin
          pulse_count <= pulse_count - CNT_ONE;
        end
      end
    end
  end

  assign w1c_bits = (wr_en && (address == ADDR_EDGECAP)) ? wd : '0;

  // Interrupt mask and edge capture; a fresh edge beats a same-cycle W1C
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqmask <= '0;
      edgecap <= '0;
    end else begin
      if (wr_en && (address == ADDR_IRQMASK)) begin
        irqmask <= wd;
      end
      edgecap <= (edgecap & ~w1c_bits) | edge_pulse;
    end
  end

  // Zero-latency read mux; upper bits read as zero
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = data_out;
      ADDR_IN:      readdata[WIDTH-1:0] = sync_value;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap;
      ADDR_PULSE:   readdata[WIDTH-1:0] = pulse_mask;
      ADDR_STATUS:  readdata[0]         = pulse_busy;
      default:      readdata            = '0;
    endcase
  end

  assign out_port = data_out;
  assign irq      = |(edgecap & irqmask);

endmodule
`default_nettype wire

// File: tb/tb_soc_system_pio_out_gen2.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_system_pio_out_gen2
// Brief    : Self-checking bench for the PIO with a deadline-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc_system_pio_out_gen2;

  localparam int PC     = 16;
  localparam int EDGE_T = 0;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] in_port;
  logic [31:0] out_port;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  soc_system_pio_out_gen2 #(
    .WIDTH        (32),
    .RESET_VALUE  (32'd1023),
    .PULSE_CYCLES (PC),
    .EDGE_TYPE    (EDGE_T)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .irq        (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  logic [31:0] m_data, m_mask, m_ec, m_pmask;
  int          m_cyc;   // clock edges since reset release
  int          m_dead;  // edge number at which the pulse bits drop
  logic [31:0] inq[$];  // inq[k] = in_port sampled at edge k+1

  task automatic model_reset();
    m_data  = 32'h3FF;
    m_mask  = 32'h0;
    m_ec    = 32'h0;
    m_pmask = 32'h0;
    m_cyc   = 0;
    m_dead  = 0;
    inq.delete();
  endtask

  task automatic model_step();
    logic [31:0] det, cur, prv, wd;
    logic        wr, pw;
    m_cyc = m_cyc + 1;
    det = 32'h0;
    // edge visible at edge n compares the inputs seen at edges n-2 and n-3
    if (m_cyc >= 4) begin
      cur = inq[m_cyc-3];
      prv = inq[m_cyc-4];
      case (EDGE_T)
        0:       det = cur & ~prv;
        1:       det = ~cur & prv;
        default: det = cur ^ prv;
      endcase
    end
    inq.push_back(in_port);
    wr = chipselect && !write_n;
    wd = writedata;
    pw = wr && (address == 3'd6);
    if ((m_dead == m_cyc) && !pw) begin
      m_data  = m_data & ~m_pmask;
      m_pmask = 32'h0;
    end
    if (wr) begin
      case (address)
        3'd0: m_data = wd;
        3'd2: m_mask = wd;
        3'd3: m_ec   = m_ec & ~wd;
        3'd4: m_data = m_data | wd;
        3'd5: m_data = m_data & ~wd;
        3'd6: begin
          m_data  = m_data | wd;
          m_pmask = m_pmask | wd;
          m_dead  = m_cyc + PC;
        end
        default: ;
      endcase
    end
    m_ec = m_ec | det;
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return m_data;
      3'd1:    return (m_cyc >= 2) ? inq[m_cyc-2] : 32'h0;
      3'd2:    return m_mask;
      3'd3:    return m_ec;
      3'd6:    return m_pmask;
      3'd7:    return {31'b0, (m_dead > m_cyc)};
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else       model_step();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      check("cyc_out_port", out_port, m_data);
      check("cyc_readdata", readdata, m_read(address));
      check("cyc_irq", {31'b0, irq}, {31'b0, |(m_ec & m_mask)});
    end
  end

  // ---------------- stimulus ----------------
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk); #1;
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  // Start a pulse, optionally inject one write at sample ra_at, count highs
  task automatic pulse_run(input logic [31:0] pdata, input int ra_at,
                           input logic [2:0] ra_addr, input logic [31:0] ra_data,
                           input int nsamp, output int c8, output int c9,
                           output logic [31:0] st_first, output logic [31:0] st_last);
    bus_write(3'd6, pdata);
    address = 3'd7;
    #1;
    c8 = 0; c9 = 0; st_first = 32'h0; st_last = 32'h0;
    for (int i = 0; i < nsamp; i++) begin
      if (out_port[8]) c8++;
      if (out_port[9]) c9++;
      if (i == 0)         st_first = readdata;
      if (i == nsamp - 1) st_last  = readdata;
      if (i == ra_at) begin
        address = ra_addr; chipselect = 1'b1; write_n = 1'b0; writedata = ra_data;
      end else begin
        address = 3'd7; chipselect = 1'b0; write_n = 1'b1;
      end
      @(negedge clk); #2;
    end
  endtask

  int          c8, c9;
  logic [31:0] s0, s1;

  initial begin
    reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'h0; in_port = 32'h0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;

    // reset state
    @(negedge clk); #1;
    check("rst_out_port", out_port, 32'h3FF);
    address = 3'd0; #1 check("rst_rd_data", readdata, 32'h3FF);
    address = 3'd7; #1 check("rst_rd_status", readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);

    // DATA / OUTSET / OUTCLR
    bus_write(3'd0, 32'hF0); check("wr_data", out_port, 32'hF0);
    bus_write(3'd4, 32'h0F); check("wr_outset", out_port, 32'hFF);
    bus_write(3'd5, 32'h81); check("wr_outclr", out_port, 32'h7E);

    // chipselect low: no effect
    @(negedge clk); #1;
    address = 3'd0; chipselect = 1'b0; write_n = 1'b0; writedata = 32'h0;
    @(negedge clk); #1 write_n = 1'b1;
    check("cs_low", out_port, 32'h7E);

    // plain pulse
    pulse_run(32'h100, -1, 3'd0, 32'h0, 40, c8, c9, s0, s1);
    check("pulse_len", c8, 16);
    check("pulse_busy", s0, 32'h1);
    check("pulse_idle", s1, 32'h0);

    // retrigger at cycle 10
    pulse_run(32'h100, 9, 3'd6, 32'h100, 40, c8, c9, s0, s1);
    check("retrig_len", c8, 26);

    // OUTSET on expiry cycle keeps the bit
    pulse_run(32'h100, 15, 3'd4, 32'h100, 40, c8, c9, s0, s1);
    check("exp_outset_len", c8, 40);
    check("exp_outset_idle", s1, 32'h0);
    bus_write(3'd5, 32'h100);

    // PULSE on expiry cycle restarts
    pulse_run(32'h100, 15, 3'd6, 32'h200, 48, c8, c9, s0, s1);
    check("exp_pulse_b8", c8, 32);
    check("exp_pulse_b9", c9, 16);
    bus_write(3'd5, 32'h300);
    check("after_pulses", out_port, 32'h7E);

    // edge capture and irq
    bus_write(3'd2, 32'h8);
    @(negedge clk); #1 in_port = 32'h8; address = 3'd3;
    @(negedge clk);
    @(negedge clk); #1 check("ecap_early", readdata, 32'h0);
    @(negedge clk); #1 check("ecap_set", readdata, 32'h8);
    check("irq_set", {31'b0, irq}, 32'h1);
    bus_write(3'd3, 32'h8);
    check("irq_w1c", {31'b0, irq}, 32'h0);

    // W1C coincident with a new rising edge
    @(negedge clk); #1 in_port = 32'h0;
    repeat (5) @(negedge clk);
    #1 in_port = 32'h8;
    @(negedge clk);
    bus_write(3'd3, 32'h8);
    address = 3'd3; #1 check("ecap_set_wins", readdata, 32'h8);
    check("irq_set_wins", {31'b0, irq}, 32'h1);
    bus_write(3'd3, 32'h8);
    check("ecap_clear", readdata, 32'h0);

    // input held high through reset: no capture
    @(negedge clk); #1 in_port = 32'hFFFF; reset = 1'b1;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    repeat (10) @(negedge clk);
    #1 address = 3'd3; #1 check("held_ecap", readdata, 32'h0);
    bus_write(3'd2, 32'hFFFF);
    check("held_irq", {31'b0, irq}, 32'h0);

    // reset mid-pulse
    bus_write(3'd6, 32'h400);
    check("mid_pulse_out", out_port, 32'h7FF);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("mid_reset_out", out_port, 32'h3FF);
    address = 3'd7; #1 check("mid_reset_status", readdata, 32'h0);
    @(negedge clk); #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
